unit_jump_resolve: RTL and testbench

Registered branch/jump resolution stage for the RVX execute path, with a built-in branch history table (BHT) for fetch-side prediction. Each cycle it accepts one control-transfer op, evaluates the condition and target, and compares the result against fetch's prediction. One cycle later it emits a registered redirect (mispredict), link address and misalignment flag. It trains a table of 2-bit saturating counters that fetch reads through a combinational lookup port.

---
 rtl/unit_jump_resolve_if.sv | 37 +++
 rtl/unit_jump_resolve.sv | 123 ++++++++++++
 tb/tb_unit_jump_resolve.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/unit_jump_resolve_if.sv
// Execute-to-fetch control-transfer bundle for unit_jump_resolve: op inputs,
// registered resolution results and the fetch-side BHT lookup port.
interface unit_jump_resolve_if #(
  parameter int XLEN = 32
);
  logic            in_valid_in;
  logic [5:0]      jump_op_in;
  logic [XLEN-1:0] src_a_in;
  logic [XLEN-1:0] src_b_in;
  logic [XLEN-1:0] imm_in;
  logic [XLEN-1:0] pc_in;
  logic            pred_taken_in;
  logic [XLEN-1:0] pred_addr_in;
  logic            flush_in;
  logic [XLEN-1:0] lookup_pc_in;
  logic            lookup_taken_out;
  logic            out_valid_out;
  logic            taken_out;
  logic            redirect_out;
  logic [XLEN-1:0] redirect_addr_out;
  logic [XLEN-1:0] link_addr_out;
  logic            misalign_out;

  modport master (
    output in_valid_in, jump_op_in, src_a_in, src_b_in, imm_in, pc_in,
           pred_taken_in, pred_addr_in, flush_in, lookup_pc_in,
    input  lookup_taken_out, out_valid_out, taken_out, redirect_out,
           redirect_addr_out, link_addr_out, misalign_out
  );

  modport slave (
    input  in_valid_in, jump_op_in, src_a_in, src_b_in, imm_in, pc_in,
           pred_taken_in, pred_addr_in, flush_in, lookup_pc_in,
    output lookup_taken_out, out_valid_out, taken_out, redirect_out,
           redirect_addr_out, link_addr_out, misalign_out
  );
endinterface

// File: rtl/unit_jump_resolve.sv
// Registered branch/jump resolution with mispredict redirect and a 2-bit BHT.
// Define JUMP_BHT_EN to build the BHT; otherwise lookup is static not-taken.
module unit_jump_resolve #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input logic              clk,
  input logic              rst,
  unit_jump_resolve_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic            is_b, is_j, is_ij, is_jump;
  logic [2:0]      funct3;
  logic            cond;
  logic            taken;
  logic [XLEN-1:0] tgt_sum, target, pc_plus4, next_pc;
  logic            misalign, redirect;
  logic            accept;

  // IJ > J > B priority when several kind bits are set
  assign is_ij   = bus.jump_op_in[2];
  assign is_j    = bus.jump_op_in[1] & ~bus.jump_op_in[2];
  assign is_b    = bus.jump_op_in[0] & ~bus.jump_op_in[1] & ~bus.jump_op_in[2];
  assign is_jump = is_b | is_j | is_ij;
  assign funct3  = bus.jump_op_in[5:3];

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (bus.src_a_in == bus.src_b_in);
      3'b001:  cond = (bus.src_a_in != bus.src_b_in);
      3'b100:  cond = ($signed(bus.src_a_in) <  $signed(bus.src_b_in));
      3'b101:  cond = ($signed(bus.src_a_in) >= $signed(bus.src_b_in));
      3'b110:  cond = (bus.src_a_in <  bus.src_b_in);
      3'b111:  cond = (bus.src_a_in >= bus.src_b_in);
      default: cond = 1'b0;
    endcase
  end

  assign taken    = (is_b & cond) | is_j | is_ij;
  assign tgt_sum  = is_ij ? (bus.src_a_in + bus.imm_in) : (bus.pc_in + bus.imm_in);
  assign target   = is_ij ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
  assign pc_plus4 = bus.pc_in + XLEN'(4);
  assign next_pc  = taken ? target : pc_plus4;
  assign misalign = taken & target[1];

  // A non-jump op retires silently even if fetch thought it was taken
  assign redirect = is_jump & ~misalign &
                    ((taken != bus.pred_taken_in) |
                     (taken & bus.pred_taken_in & (bus.pred_addr_in != target)));

  assign accept = bus.in_valid_in & ~bus.flush_in;

  logic            valid_q,    valid_d;
  logic            taken_q,    taken_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] raddr_q,    raddr_d;
  logic [XLEN-1:0] link_q,     link_d;

  assign valid_d    = accept;
  assign taken_d    = accept & taken;
  assign redirect_d = accept & redirect;
  assign misalign_d = accept & misalign;
  assign raddr_d    = accept ? next_pc  : raddr_q;
  assign link_d     = accept ? pc_plus4 : link_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      raddr_q    <= '0;
      link_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      raddr_q    <= raddr_d;
      link_q     <= link_d;
    end
  end

  assign bus.out_valid_out     = valid_q;
  assign bus.taken_out         = taken_q;
  assign bus.redirect_out      = redirect_q;
  assign bus.misalign_out      = misalign_q;
  assign bus.redirect_addr_out = raddr_q;
  assign bus.link_addr_out     = link_q;

  // Upper lookup PC bits never index the table
  logic unused_lookup;
  assign unused_lookup = ^bus.lookup_pc_in;

`ifdef JUMP_BHT_EN
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] upd_idx, lk_idx;
  logic             bht_upd;

  assign upd_idx = bus.pc_in[IDX_W+1:2];
  assign lk_idx  = bus.lookup_pc_in[IDX_W+1:2];
  assign bht_upd = accept & is_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (bht_upd) begin
      if (taken && bht_q[upd_idx] != 2'b11)
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      else if (!taken && bht_q[upd_idx] != 2'b00)
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
    end
  end

  // Reads the array before this cycle's write lands: pre-update on a same-index hit
  assign bus.lookup_taken_out = bht_q[lk_idx][1];
`else
  assign bus.lookup_taken_out = 1'b0;
`endif
endmodule

// File: tb/tb_unit_jump_resolve.sv
// Directed testbench for unit_jump_resolve; expectations are hand-computed and
// BHT expectations collapse to 0 when JUMP_BHT_EN is not defined.
module tb_unit_jump_resolve;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef JUMP_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  unit_jump_resolve_if #(.XLEN(32)) bus ();

  unit_jump_resolve #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic pt, input logic [31:0] pa);
    bus.in_valid_in   = 1'b1;
    bus.flush_in      = 1'b0;
    bus.jump_op_in    = op;
    bus.src_a_in      = a;
    bus.src_b_in      = b;
    bus.imm_in        = imm;
    bus.pc_in         = pc;
    bus.pred_taken_in = pt;
    bus.pred_addr_in  = pa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic pt, input logic [31:0] pa);
    set_op(op, a, b, imm, pc, pt, pa);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid_in   = 1'b0;
    bus.flush_in      = 1'b0;
    bus.jump_op_in    = '0;
    bus.src_a_in      = '0;
    bus.src_b_in      = '0;
    bus.imm_in        = '0;
    bus.pc_in         = '0;
    bus.pred_taken_in = 1'b0;
    bus.pred_addr_in  = '0;
    bus.lookup_pc_in  = 32'h40;
    #12;
    chk("rst_valid",    32'(bus.out_valid_out), 32'd0);
    chk("rst_taken",    32'(bus.taken_out), 32'd0);
    chk("rst_redirect", 32'(bus.redirect_out), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_out), 32'd0);
    chk("rst_raddr",    bus.redirect_addr_out, 32'h0);
    chk("rst_link",     bus.link_addr_out, 32'h0);
    chk("rst_lookup",   32'(bus.lookup_taken_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, predicted not taken
    step(6'h01, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0);
    chk("beq_valid",    32'(bus.out_valid_out), 32'd1);
    chk("beq_taken",    32'(bus.taken_out), 32'd1);
    chk("beq_redirect", 32'(bus.redirect_out), 32'd1);
    chk("beq_raddr",    bus.redirect_addr_out, 32'h120);
    chk("beq_link",     bus.link_addr_out, 32'h104);
    chk("beq_misalign", 32'(bus.misalign_out), 32'd0);

    // JALR clears target LSB; prediction matches
    step(6'h04, 32'h2001, 32'h0, 32'h0, 32'h200, 1'b1, 32'h2000);
    chk("jalr_taken",    32'(bus.taken_out), 32'd1);
    chk("jalr_redirect", 32'(bus.redirect_out), 32'd0);
    chk("jalr_raddr",    bus.redirect_addr_out, 32'h2000);
    chk("jalr_link",     bus.link_addr_out, 32'h204);

    // JAL misaligned target 0x106
    step(6'h02, 32'h0, 32'h0, 32'h6, 32'h100, 1'b0, 32'h0);
    chk("jal_misalign", 32'(bus.misalign_out), 32'd1);
    chk("jal_redirect", 32'(bus.redirect_out), 32'd0);
    chk("jal_link",     bus.link_addr_out, 32'h104);

    // BLT signed: -1 < 1 taken
    step(6'h21, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h300, 1'b0, 32'h0);
    chk("blt_taken",    32'(bus.taken_out), 32'd1);
    chk("blt_raddr",    bus.redirect_addr_out, 32'h310);

    // BLTU: 0xFFFFFFFF < 1 false; predicted taken so redirect to pc+4
    step(6'h31, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h300, 1'b1, 32'h310);
    chk("bltu_taken",    32'(bus.taken_out), 32'd0);
    chk("bltu_redirect", 32'(bus.redirect_out), 32'd1);
    chk("bltu_raddr",    bus.redirect_addr_out, 32'h304);

    // BGE / BGEU complementary case
    step(6'h29, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h300, 1'b0, 32'h0);
    chk("bge_taken",    32'(bus.taken_out), 32'd0);
    step(6'h39, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h300, 1'b1, 32'h310);
    chk("bgeu_taken",    32'(bus.taken_out), 32'd1);
    chk("bgeu_redirect", 32'(bus.redirect_out), 32'd0);

    // funct3 010 never taken even with equal operands
    step(6'h11, 32'h7, 32'h7, 32'h10, 32'h300, 1'b0, 32'h0);
    chk("f010_taken",    32'(bus.taken_out), 32'd0);
    chk("f010_redirect", 32'(bus.redirect_out), 32'd0);

    // All kind bits set: IJ wins, target = src_a+imm
    step(6'h07, 32'h1000, 32'h0, 32'h8, 32'h500, 1'b1, 32'h1008);
    chk("prio_redirect", 32'(bus.redirect_out), 32'd0);
    chk("prio_raddr",    bus.redirect_addr_out, 32'h1008);

    // Non-jump op never redirects, even when predicted taken
    step(6'h00, 32'h0, 32'h0, 32'h0, 32'h600, 1'b1, 32'h700);
    chk("nj_valid",    32'(bus.out_valid_out), 32'd1);
    chk("nj_redirect", 32'(bus.redirect_out), 32'd0);
    chk("nj_link",     bus.link_addr_out, 32'h604);

    // Idle: flags clear, addresses hold
    bus.in_valid_in = 1'b0;
    set_op(6'h02, 32'h0, 32'h0, 32'h40, 32'h900, 1'b0, 32'h0);
    bus.in_valid_in = 1'b0;
    tick();
    chk("idle_valid", 32'(bus.out_valid_out), 32'd0);
    chk("idle_taken", 32'(bus.taken_out), 32'd0);
    chk("idle_raddr", bus.redirect_addr_out, 32'h604);
    chk("idle_link",  bus.link_addr_out, 32'h604);

    // BHT training at 0x40 (index 16)
    bus.lookup_pc_in = 32'h40;
    set_op(6'h09, 32'h1, 32'h2, 32'h10, 32'h40, 1'b1, 32'h50);
    #1;
    chk("bht_pre", 32'(bus.lookup_taken_out), 32'd0);
    tick();
    chk("bne1_redirect", 32'(bus.redirect_out), 32'd0);
    chk("bht_1", 32'(bus.lookup_taken_out), 32'(BHT));
    step(6'h09, 32'h1, 32'h2, 32'h10, 32'h40, 1'b1, 32'h50);
    chk("bht_2", 32'(bus.lookup_taken_out), 32'(BHT));
    step(6'h09, 32'h1, 32'h2, 32'h10, 32'h40, 1'b1, 32'h50);
    chk("bht_3", 32'(bus.lookup_taken_out), 32'(BHT));
    step(6'h09, 32'h3, 32'h3, 32'h10, 32'h40, 1'b1, 32'h50);
    chk("bht_nt1", 32'(bus.lookup_taken_out), 32'(BHT));
    // counter now 2; a second not-taken takes it to 1 but lookup sees old value first
    set_op(6'h09, 32'h3, 32'h3, 32'h10, 32'h40, 1'b0, 32'h0);
    #1;
    chk("bht_same_cycle", 32'(bus.lookup_taken_out), 32'(BHT));
    tick();
    chk("bht_nt2", 32'(bus.lookup_taken_out), 32'd0);

    // Flush with a valid taken BNE: discarded, no BHT update
    set_op(6'h09, 32'h1, 32'h2, 32'h10, 32'h40, 1'b0, 32'h0);
    bus.flush_in = 1'b1;
    tick();
    chk("flush_valid",    32'(bus.out_valid_out), 32'd0);
    chk("flush_redirect", 32'(bus.redirect_out), 32'd0);
    chk("flush_misalign", 32'(bus.misalign_out), 32'd0);
    chk("flush_bht",      32'(bus.lookup_taken_out), 32'd0);

    // Wrap-around: not-taken branch at 0xFFFFFFFC predicted taken
    step(6'h01, 32'h1, 32'h2, 32'h10, 32'hFFFFFFFC, 1'b1, 32'h1234);
    chk("wrap_redirect", 32'(bus.redirect_out), 32'd1);
    chk("wrap_raddr",    bus.redirect_addr_out, 32'h0);
    chk("wrap_link",     bus.link_addr_out, 32'h0);
    step(6'h02, 32'h0, 32'h0, 32'h20, 32'hFFFFFFF0, 1'b0, 32'h0);
    chk("wrap_jal_raddr", bus.redirect_addr_out, 32'h10);

    // Mid-stream async reset after training the counter back up to 2
    step(6'h09, 32'h1, 32'h2, 32'h10, 32'h40, 1'b0, 32'h0);
    chk("pre_rst_valid",  32'(bus.out_valid_out), 32'd1);
    chk("pre_rst_lookup", 32'(bus.lookup_taken_out), 32'(BHT));
    bus.in_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    32'(bus.out_valid_out), 32'd0);
    chk("arst_taken",    32'(bus.taken_out), 32'd0);
    chk("arst_redirect", 32'(bus.redirect_out), 32'd0);
    chk("arst_raddr",    bus.redirect_addr_out, 32'h0);
    chk("arst_link",     bus.link_addr_out, 32'h0);
    chk("arst_lookup",   32'(bus.lookup_taken_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
